// File: rtl/addr_req_queue.sv
// Buffers generator addresses in a small FIFO and issues them as memory read
// requests, bracketing each x_max*y_max frame with start/busy/done control.
module addr_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] x_max,
  input  logic [CW-1:0] y_max,
  input  logic [AW-1:0] in_addr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] req_addr,
  output logic          req_last,
  output logic          req_valid,
  input  logic          req_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   total_q, total_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic            done_q, done_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]   cnt_q;
  logic [AW-1:0]   mem_addr [DEPTH];
  logic [DEPTH-1:0] mem_last;

  logic [CW-1:0]   prod_c;
  logic            full_c, empty_c, push_c, pop_c, last_in_c, head_last_c;

  assign prod_c      = x_max * y_max;
  assign full_c      = (cnt_q == OW'(DEPTH));
  assign empty_c     = (cnt_q == '0);
  assign last_in_c   = (acc_q == total_q - CW'(1));
  assign head_last_c = mem_last[rd_ptr_q];

  // Both handshake-ready signals derive from registered state only.
  assign in_ready  = (state_q == S_RUN) && !full_c && (acc_q < total_q);
  assign req_valid = !empty_c;
  assign req_addr  = empty_c ? '0 : mem_addr[rd_ptr_q];
  assign req_last  = !empty_c && head_last_c;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  assign push_c = in_valid && in_ready;
  assign pop_c  = req_valid && req_ready;

  // Frame control next-state logic.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          total_d = prod_c;
          acc_d   = '0;
          if (prod_c == '0) done_d  = 1'b1;
          else              state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (push_c) begin
          acc_d = acc_q + CW'(1);
          if (last_in_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase
    if (pop_c && head_last_c) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      total_q <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + OW'(1);
        2'b01:   cnt_q <= cnt_q - OW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_addr[wr_ptr_q] <= in_addr;
      mem_last[wr_ptr_q] <= last_in_c;
    end
  end

endmodule
